hs_rr_arbiter: RTL

Clocked round-robin arbiter that shares one 4-phase req/ack handshake pipeline input channel among N_REQ requesters.
- Each requester presents a 4-phase channel: req, ack and a DATA_W data word.
- The arbiter grants one requester, forwards its word through one complete 4-phase transaction on the pipeline, then completes the requester's handshake.
- Sits in front of the async handshake pipeline top level, in place of a single direct sender.

---
 rtl/hs_arb_pkg.sv | 14 +
 rtl/hs_rr_pick.sv | 28 ++
 rtl/hs_rr_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hs_arb_pkg.sv
// Shared types and default sizes for the round-robin handshake arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    P_REQ = 2'd1,
    P_REL = 2'd2,
    C_ACK = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational round-robin select: first asserted request at or after ptr, wrapping.
module hs_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  winner_o
);

  int idx;

  // Walk offsets from the pointer; the first hit wins, later hits are ignored.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!valid_o && req_i[idx[ID_W-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase pipeline input among N_REQ requesters.
// Define HS_ARB_SYNC_EN to pass req_i and pipe_ack_i through 2-flop synchronizers.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  output logic [N_REQ-1:0]        ack_o,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic                    pipe_req_o,
  input  logic                    pipe_ack_i,
  output logic [DATA_W-1:0]       pipe_data_o,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    busy_o
);

  logic [N_REQ-1:0] req_use;
  logic             pack_use;

`ifdef HS_ARB_SYNC_EN
  logic [N_REQ-1:0] req_s1_q, req_s2_q;
  logic             pack_s1_q, pack_s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_s1_q  <= '0;
      req_s2_q  <= '0;
      pack_s1_q <= 1'b0;
      pack_s2_q <= 1'b0;
    end else begin
      req_s1_q  <= req_i;
      req_s2_q  <= req_s1_q;
      pack_s1_q <= pipe_ack_i;
      pack_s2_q <= pack_s1_q;
    end
  end

  assign req_use  = req_s2_q;
  assign pack_use = pack_s2_q;
`else
  assign req_use  = req_i;
  assign pack_use = pipe_ack_i;
`endif

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              pipe_req_q, pipe_req_d;
  logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_winner;

  hs_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i    (req_use),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  // Next-state and next-output logic; every output is a flop fed from here.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    pipe_req_d  = pipe_req_q;
    pipe_data_d = pipe_data_q;
    case (state_q)
      IDLE: begin
        // A lingering pipeline ack (e.g. after a mid-transfer reset) blocks new grants.
        if (!pack_use && pick_valid) begin
          grant_d     = pick_winner;
          pipe_data_d = data_i[int'(pick_winner)*DATA_W +: DATA_W];
          pipe_req_d  = 1'b1;
          state_d     = P_REQ;
        end
      end
      P_REQ: begin
        if (pack_use) begin
          pipe_req_d = 1'b0;
          state_d    = P_REL;
        end
      end
      P_REL: begin
        if (!pack_use) begin
          ack_d   = N_REQ'(1) << grant_q;
          state_d = C_ACK;
        end
      end
      C_ACK: begin
        if (!req_use[grant_q]) begin
          ack_d   = '0;
          ptr_d   = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      pipe_req_q  <= 1'b0;
      pipe_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      pipe_req_q  <= pipe_req_d;
      pipe_data_q <= pipe_data_d;
      busy_q      <= busy_d;
    end
  end

  assign ack_o       = ack_q;
  assign pipe_req_o  = pipe_req_q;
  assign pipe_data_o = pipe_data_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;

endmodule
